uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Downstream stage of the UART receive sampler, in the same serial transceiver.
- Consumes the sampler's one-cycle mid-bit strobe plus the raw serial line, and shifts in the data bits LSB first.
- Checks optional parity and the stop bit.
- Presents each completed byte through a held valid/ready output register with error pulses for the host side.

Parameters:
DATA_BITS, 8, number of data bits per frame (legal 5..9).
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
BIT_CYCLES, 16, sample_clk cycles per bit period (matches the sampler's ratio).
TIMEOUT_CYCLES, 2*BIT_CYCLES, cycles without a strobe that abort a partial frame.

Ports:
sample_clk  input  1  receive clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  1  serial line, already synchronised, idle high.
sample_sig  input  1  one-cycle strobe from the sampler; din is valid in that cycle.
rx_data  output  DATA_BITS  received word, stable while rx_valid = 1.
rx_valid  output  1  word available; held until accepted.
rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready.
frame_err  output  1  one-cycle pulse: stop bit sampled 0.
parity_err  output  1  one-cycle pulse: parity mismatch.
overrun_err  output  1  one-cycle pulse: good frame dropped because the holding register was full.
frame_abort  output  1  one-cycle pulse: timeout mid-frame.

Behaviour:
- Reset (rst_n = 0, any time, asynchronous): state = IDLE, shift register = 0, bit index = 0, timeout count = 0, rx_data = 0, rx_valid = 0, all error pulses = 0. A partial frame is discarded; no error is flagged.
- States:
  - IDLE: the first strobe samples data bit 0 and moves to DATA.
  - DATA: each strobe shifts din in at the MSB and right-shifts, so bit 0 ends at LSB; the bit index increments. After strobe number DATA_BITS, go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: the strobe captures the parity bit and moves to STOP.
  - STOP: the strobe samples the stop bit, evaluates the frame, and returns to IDLE.
- Parity: expected = XOR of the data bits, inverted for odd mode. Parity is compared at the stop strobe.
- Frame evaluation at the stop strobe, in priority order:
  - Stop bit = 0 -> frame_err; word dropped. parity_err is not flagged in this case.
  - Otherwise, parity mismatch -> parity_err; word dropped.
  - Otherwise the frame is good:
    - If rx_valid = 0, or rx_valid & rx_ready in this same cycle -> load rx_data; rx_valid = 1.
    - Else -> overrun_err; the old word is kept unchanged.
- Latency: rx_valid, rx_data and the error pulses are registered and appear on the edge immediately after the stop-strobe cycle.
- Handshake:
  - rx_valid & rx_ready clears rx_valid on the next edge, unless a good frame loads in the same cycle; then rx_valid stays 1 with the new data.
  - rx_ready is ignored while rx_valid = 0.
- Timeout:
  - The counter runs outside IDLE and clears on every strobe.
  - On reaching TIMEOUT_CYCLES-1 with no strobe: frame_abort pulse, return to IDLE.
  - A strobe in the same cycle as the timeout wins: no abort.
- A strobe while in IDLE never checks din: the upstream sampler guarantees start-bit alignment.
- Counter widths: bit index is clog2(DATA_BITS+2) bits; timeout counter is clog2(TIMEOUT_CYCLES) bits.
- The pulse outputs are mutually exclusive per cycle.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum (IDLE, DATA, PARITY, STOP);
  - PARITY_NONE/EVEN/ODD constants;
  - a parity function.
- These constants are reused by the transmit side.
- One sub-module is natural: uart_rx_timeout, a loadable down-counter with clear-on-strobe and an expiry pulse.
- The main FSM, shift register and output register stay in uart_rx_deserializer.

Test Plan:
1. PARITY_MODE = 0. Strobes with din = 1,0,1,0,0,1,0,1 then stop = 1 -> rx_data = 0xA5 and rx_valid = 1 one cycle after the 9th strobe. Then rx_ready = 1 -> rx_valid = 0 on the next edge.
2. PARITY_MODE = 1, data 0x03, parity bit 0 -> rx_data = 0x03 valid. Repeat with parity bit 1 -> parity_err pulse, rx_valid stays 0.
3. Data 0x55 with stop bit 0 -> single frame_err pulse, no rx_valid. The next good frame 0x12 is received normally.
4. Receive 0x11 and hold rx_ready = 0, then receive 0x22 -> overrun_err pulse, rx_data stays 0x11. Repeat with rx_ready = 1 in the 0x22 stop-strobe cycle -> rx_data = 0x22, rx_valid continuous, no overrun.
5. Three strobes, then silence for TIMEOUT_CYCLES (32) -> frame_abort at cycle 31 after the last strobe. The following full frame 0x7E decodes correctly.
6. Deassert rst_n mid-DATA (after 4 strobes) -> all outputs 0 immediately. After release, frame 0xC3 decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity modes and the parity helper.
// The transmit side imports the same constants.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned PARITY_NONE   = 0;
    localparam int unsigned PARITY_EVEN   = 1;
    localparam int unsigned PARITY_ODD    = 2;
    localparam int unsigned MAX_DATA_BITS = 9;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int unsigned              mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Sampler-side inputs and host-side word/error outputs of the UART receive deserializer.
interface uart_rx_deserializer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 din;
    logic                 sample_sig;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;
    logic                 frame_abort;

    modport master (
        input  din, sample_sig, rx_ready,
        output rx_data, rx_valid, frame_err, parity_err, overrun_err, frame_abort
    );

    modport slave (
        output din, sample_sig, rx_ready,
        input  rx_data, rx_valid, frame_err, parity_err, overrun_err, frame_abort
    );
endinterface

// File: rtl/uart_rx_timeout.sv
// Strobe watchdog: reloads on every strobe and flags expiry once TIMEOUT_CYCLES-1 edges pass
// without one while a frame is in progress.
module uart_rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic strobe_i,
    output logic expire_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (strobe_i) begin
            cnt_d = LoadVal;
        end else if (!active_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A strobe arriving in the expiry cycle reloads the counter instead of aborting.
    assign expire_o = active_i & ~strobe_i & (cnt_q == CntW'(1));

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: shifts strobed bits LSB first, checks parity and stop bit, and
// holds each good word in a valid/ready register with one-cycle error pulses.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY_MODE    = PARITY_NONE,
    parameter int unsigned BIT_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2 * BIT_CYCLES
) (
    input logic                   sample_clk,
    input logic                   rst_n,
    uart_rx_deserializer_if.master bus
);
    localparam int unsigned IdxW = $clog2(DATA_BITS + 2);

    rx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 abort_q, abort_d;
    logic                 strobe;
    logic                 expire;
    logic                 par_ok;

    assign strobe = bus.sample_sig;
    assign par_ok = (PARITY_MODE == PARITY_NONE) ||
                    (par_q == parity_bit(MAX_DATA_BITS'(shift_q), PARITY_MODE));

    uart_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (sample_clk),
        .rst_ni  (rst_n),
        .active_i(state_q != StIdle),
        .strobe_i(strobe),
        .expire_o(expire)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        idx_d   = idx_q;
        par_d   = par_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        ovr_d   = 1'b0;
        abort_d = 1'b0;

        if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    shift_d = {bus.din, shift_q[DATA_BITS-1:1]};
                    idx_d   = IdxW'(1);
                    state_d = StData;
                end
            end
            StData: begin
                if (strobe) begin
                    shift_d = {bus.din, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IdxW'(DATA_BITS - 1)) begin
                        state_d = (PARITY_MODE != PARITY_NONE) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (strobe) begin
                    par_d   = bus.din;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (strobe) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    // A bad stop bit masks any parity result.
                    if (!bus.din) begin
                        ferr_d = 1'b1;
                    end else if (!par_ok) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || bus.rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
        endcase

        if (expire) begin
            state_d = StIdle;
            idx_d   = '0;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
            abort_q <= abort_d;
        end
    end

    assign bus.rx_data     = data_q;
    assign bus.rx_valid    = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.parity_err  = perr_q;
    assign bus.overrun_err = ovr_q;
    assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomised bench for uart_rx_deserializer: one DUT without parity, one with even parity,
// each compared against a frame-level model of the holding register.
module tb_uart_rx_deserializer;
    localparam int unsigned DB = 8;
    localparam int unsigned BC = 16;
    localparam int unsigned TO = 2 * BC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] din_v = 2'b11;
    logic [1:0] stb_v = 2'b00;
    logic [1:0] rdy_v = 2'b00;

    uart_rx_deserializer_if #(.DATA_BITS(DB)) bus0 ();
    uart_rx_deserializer_if #(.DATA_BITS(DB)) bus1 ();

    assign bus0.din        = din_v[0];
    assign bus0.sample_sig = stb_v[0];
    assign bus0.rx_ready   = rdy_v[0];
    assign bus1.din        = din_v[1];
    assign bus1.sample_sig = stb_v[1];
    assign bus1.rx_ready   = rdy_v[1];

    uart_rx_deserializer #(
        .DATA_BITS(DB), .PARITY_MODE(0), .BIT_CYCLES(BC), .TIMEOUT_CYCLES(TO)
    ) dut0 (
        .sample_clk(clk),
        .rst_n     (rst_n),
        .bus       (bus0)
    );

    uart_rx_deserializer #(
        .DATA_BITS(DB), .PARITY_MODE(1), .BIT_CYCLES(BC), .TIMEOUT_CYCLES(TO)
    ) dut1 (
        .sample_clk(clk),
        .rst_n     (rst_n),
        .bus       (bus1)
    );

    logic [DB-1:0] o_data [2];
    logic [1:0]    o_valid, o_ferr, o_perr, o_ovr, o_abort;
    assign o_data[0] = bus0.rx_data;
    assign o_data[1] = bus1.rx_data;
    assign o_valid   = {bus1.rx_valid, bus0.rx_valid};
    assign o_ferr    = {bus1.frame_err, bus0.frame_err};
    assign o_perr    = {bus1.parity_err, bus0.parity_err};
    assign o_ovr     = {bus1.overrun_err, bus0.overrun_err};
    assign o_abort   = {bus1.frame_abort, bus0.frame_abort};

    int checks = 0;
    int errors = 0;
    int seen_abort = 0;

    // Reference model: parity mode per DUT and its holding register.
    int            mode [2] = '{0, 1};
    bit            m_valid [2] = '{1'b0, 1'b0};
    logic [DB-1:0] m_data [2];

    function automatic bit exp_parity(input logic [DB-1:0] d, input int m);
        return (($countones(d) % 2) == 1) ^ (m == 2);
    endfunction

    task automatic tick(input int s);
        @(negedge clk);
        if (o_abort[s] === 1'b1) seen_abort++;
    endtask

    task automatic gap(input int s, input int n);
        repeat (n) tick(s);
    endtask

    task automatic pulse_bit(input int s, input logic b);
        din_v[s] = b;
        stb_v[s] = 1'b1;
        tick(s);
        stb_v[s] = 1'b0;
        din_v[s] = 1'b1;
    endtask

    task automatic consume(input int s);
        rdy_v[s] = 1'b1;
        tick(s);
        rdy_v[s] = 1'b0;
        m_valid[s] = 1'b0;
        checks++;
        if (o_valid[s] !== 1'b0) begin
            errors++;
            $display("FAIL consume s%0d rx_valid got %0b want 0", s, o_valid[s]);
        end
    endtask

    task automatic send_frame(input int s, input logic [DB-1:0] data, input bit par_flip,
                              input bit stop, input bit rdy, input int max_gap,
                              input int long_at, input string name);
        int a0;
        bit consumed, ef, ep, eo;
        a0 = seen_abort;
        for (int i = 0; i < int'(DB); i++) begin
            pulse_bit(s, data[i]);
            if (i == long_at) gap(s, int'(TO) - 2);
            else gap(s, int'($urandom_range(max_gap, 0)));
        end
        if (mode[s] != 0) begin
            pulse_bit(s, exp_parity(data, mode[s]) ^ par_flip);
            gap(s, int'($urandom_range(max_gap, 0)));
        end
        din_v[s] = stop;
        stb_v[s] = 1'b1;
        rdy_v[s] = rdy;
        tick(s);
        stb_v[s] = 1'b0;
        rdy_v[s] = 1'b0;
        din_v[s] = 1'b1;

        consumed = m_valid[s] && rdy;
        ef = !stop;
        ep = stop && (mode[s] != 0) && par_flip;
        eo = 1'b0;
        if (!ef && !ep) begin
            if (!m_valid[s] || consumed) begin
                m_data[s]  = data;
                m_valid[s] = 1'b1;
            end else begin
                eo = 1'b1;
            end
        end else if (consumed) begin
            m_valid[s] = 1'b0;
        end

        checks++;
        if (o_valid[s] !== m_valid[s]) begin
            errors++;
            $display("FAIL %s rx_valid got %0b want %0b", name, o_valid[s], m_valid[s]);
        end
        checks++;
        if (o_data[s] !== m_data[s]) begin
            errors++;
            $display("FAIL %s rx_data got %h want %h", name, o_data[s], m_data[s]);
        end
        checks++;
        if (o_ferr[s] !== ef) begin
            errors++;
            $display("FAIL %s frame_err got %0b want %0b", name, o_ferr[s], ef);
        end
        checks++;
        if (o_perr[s] !== ep) begin
            errors++;
            $display("FAIL %s parity_err got %0b want %0b", name, o_perr[s], ep);
        end
        checks++;
        if (o_ovr[s] !== eo) begin
            errors++;
            $display("FAIL %s overrun_err got %0b want %0b", name, o_ovr[s], eo);
        end
        tick(s);
        checks++;
        if ({o_ferr[s], o_perr[s], o_ovr[s], o_abort[s]} !== 4'b0000) begin
            errors++;
            $display("FAIL %s pulses_cleared got %b want 0000", name,
                     {o_ferr[s], o_perr[s], o_ovr[s], o_abort[s]});
        end
        checks++;
        if (seen_abort != a0) begin
            errors++;
            $display("FAIL %s frame_abort count got %0d want 0", name, seen_abort - a0);
        end
    endtask

    task automatic test_reset();
        #3;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({o_valid[s], o_ferr[s], o_perr[s], o_ovr[s], o_abort[s]} !== 5'b0 ||
                o_data[s] !== '0) begin
                errors++;
                $display("FAIL reset s%0d outputs got v=%b d=%h want all zero", s,
                         {o_valid[s], o_ferr[s], o_perr[s], o_ovr[s], o_abort[s]}, o_data[s]);
            end
        end
        m_data[0] = '0;
        m_data[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 0, -1, "basic_a5");
        consume(0);
        send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1, 3, -1, "basic_00_ready_idle");
        consume(0);
    endtask

    task automatic test_parity();
        send_frame(1, 8'h03, 1'b0, 1'b1, 1'b0, 2, -1, "parity_ok_03");
        consume(1);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b0, 2, -1, "parity_bad_03");
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0, 2, -1, "parity_and_stop_bad");
    endtask

    task automatic test_frame_err();
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 2, -1, "stop_bad_55");
        send_frame(0, 8'h12, 1'b0, 1'b1, 1'b0, 2, -1, "after_ferr_12");
        consume(0);
    endtask

    task automatic test_overrun();
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 2, -1, "ovr_first_11");
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 2, -1, "ovr_drop_22");
        consume(0);
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 2, -1, "b2b_first_11");
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 2, -1, "b2b_load_22");
        consume(0);
    endtask

    task automatic test_timeout();
        int a0, c0, delay;
        bit found;
        a0 = seen_abort;
        pulse_bit(0, 1'b0);
        pulse_bit(0, 1'b1);
        pulse_bit(0, 1'b1);
        c0 = cyc;
        found = 1'b0;
        delay = -1;
        for (int k = 0; k < int'(TO) + 8 && !found; k++) begin
            tick(0);
            if (seen_abort != a0) begin
                found = 1'b1;
                delay = cyc - c0;
            end
        end
        checks++;
        if (!found || delay != int'(TO) - 1) begin
            errors++;
            $display("FAIL timeout_delay got %0d want %0d", delay, int'(TO) - 1);
        end
        tick(0);
        checks++;
        if (o_abort[0] !== 1'b0 || o_valid[0] !== m_valid[0]) begin
            errors++;
            $display("FAIL timeout_pulse_once got abort=%0b valid=%0b want 0 %0b",
                     o_abort[0], o_valid[0], m_valid[0]);
        end
        send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b0, 4, -1, "after_abort_7e");
        consume(0);
        send_frame(0, 8'h9B, 1'b0, 1'b1, 1'b0, 0, 2, "strobe_beats_timeout");
        consume(0);
    endtask

    task automatic test_reset_mid();
        logic [DB-1:0] w;
        w = 8'hC3;
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0, 2, -1, "preload_3c");
        for (int i = 0; i < 4; i++) pulse_bit(0, w[i]);
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({o_valid[s], o_ferr[s], o_perr[s], o_ovr[s], o_abort[s]} !== 5'b0 ||
                o_data[s] !== '0) begin
                errors++;
                $display("FAIL async_reset s%0d got v=%b d=%h want all zero", s,
                         {o_valid[s], o_ferr[s], o_perr[s], o_ovr[s], o_abort[s]}, o_data[s]);
            end
            m_valid[s] = 1'b0;
            m_data[s]  = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(0);
        send_frame(0, w, 1'b0, 1'b1, 1'b0, 2, -1, "after_reset_c3");
        consume(0);
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 40; n++) begin
            s = int'($urandom_range(1, 0));
            send_frame(s, DB'($urandom), ($urandom_range(3, 0) == 0),
                       ($urandom_range(7, 0) != 0), 1'($urandom), int'(BC) - 1, -1, "random");
            if ($urandom_range(2, 0) == 0) consume(s);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
